// File: rtl/madd_sched_if.sv
// Requester, response, MADD operand/result and flush signals of madd_sched.
// master = surrounding environment (requesters + MADD unit), slave = the scheduler.
interface madd_sched_if;
  logic        REQ0_VALID;
  logic        REQ0_READY;
  logic [31:0] REQ0_A;
  logic [31:0] REQ0_B;
  logic [31:0] REQ0_C;
  logic        REQ1_VALID;
  logic        REQ1_READY;
  logic [31:0] REQ1_A;
  logic [31:0] REQ1_B;
  logic [31:0] REQ1_C;
  logic        RSP0_VALID;
  logic [31:0] RSP0_Z;
  logic        RSP1_VALID;
  logic [31:0] RSP1_Z;
  logic [31:0] MADD_A;
  logic [31:0] MADD_B;
  logic [31:0] MADD_C;
  logic [31:0] MADD_Z;
  logic        FLUSH;
  logic        FLUSH_DONE;
  logic        BUSY;

  // A triple transfers on a cycle where VALID and READY are both high; READY
  // never waits on anything later in the cycle, and responses have no backpressure.
  modport master (
    output REQ0_VALID, REQ0_A, REQ0_B, REQ0_C,
    output REQ1_VALID, REQ1_A, REQ1_B, REQ1_C,
    input  REQ0_READY, REQ1_READY,
    input  RSP0_VALID, RSP0_Z, RSP1_VALID, RSP1_Z,
    input  MADD_A, MADD_B, MADD_C,
    output MADD_Z,
    output FLUSH,
    input  FLUSH_DONE, BUSY
  );

  modport slave (
    input  REQ0_VALID, REQ0_A, REQ0_B, REQ0_C,
    input  REQ1_VALID, REQ1_A, REQ1_B, REQ1_C,
    output REQ0_READY, REQ1_READY,
    output RSP0_VALID, RSP0_Z, RSP1_VALID, RSP1_Z,
    output MADD_A, MADD_B, MADD_C,
    input  MADD_Z,
    input  FLUSH,
    output FLUSH_DONE, BUSY
  );
endinterface

// File: rtl/madd_sched.sv
// Round-robin sharing of one pipelined MADD (Z = A*B + C) between two requesters.
// Define MADD_SCHED_STATS_EN to add per-requester issue counters ISSUE_CNT0/ISSUE_CNT1.
module madd_sched #(
  parameter int LAT       = 1,
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  madd_sched_if.slave      bus,
`ifdef MADD_SCHED_STATS_EN
  output logic [CNT_W-1:0] ISSUE_CNT0,
  output logic [CNT_W-1:0] ISSUE_CNT1,
`endif
  output logic             fsm_state
);

  if (LAT < 1) begin : g_bad_lat
    $error("madd_sched: LAT must be >= 1");
  end
  if (MAX_OUTST < 1 || MAX_OUTST > LAT + 1) begin : g_bad_outst
    $error("madd_sched: MAX_OUTST must be in 1..LAT+1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("madd_sched: CNT_W must be >= 1");
  end

  localparam int OW = $clog2(MAX_OUTST + 1);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t          state;
  logic            ptr;
  logic [OW-1:0]   outst;
  logic [OW-1:0]   outst_next;
  logic [LAT-1:0]  tag_v;
  logic [LAT-1:0]  tag_id;

  logic            grantable;
  logic            gnt0;
  logic            gnt1;
  logic            accept;
  logic            rsp_fire;
  logic            rsp_id;
  logic [31:0]     acc_a;
  logic [31:0]     acc_b;
  logic [31:0]     acc_c;

  // FLUSH blocks the grant in its own cycle, so nothing new enters once a drain starts.
  always_comb begin
    grantable  = (state == S_RUN) && !bus.FLUSH && (outst < OW'(MAX_OUTST));
    gnt0       = grantable && bus.REQ0_VALID && (!bus.REQ1_VALID || !ptr);
    gnt1       = grantable && bus.REQ1_VALID && (!bus.REQ0_VALID || ptr);
    accept     = gnt0 || gnt1;
    acc_a      = gnt1 ? bus.REQ1_A : bus.REQ0_A;
    acc_b      = gnt1 ? bus.REQ1_B : bus.REQ0_B;
    acc_c      = gnt1 ? bus.REQ1_C : bus.REQ0_C;
    rsp_fire   = tag_v[LAT-1];
    rsp_id     = tag_id[LAT-1];
    outst_next = outst;
    if (accept && !rsp_fire) begin
      outst_next = outst + 1'b1;
    end else if (!accept && rsp_fire) begin
      outst_next = outst - 1'b1;
    end
  end

  assign bus.REQ0_READY = gnt0;
  assign bus.REQ1_READY = gnt1;
  assign fsm_state      = (state == S_DRAIN);

  // The RSP register is the last stage of the LAT+1 deep tag pipeline.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= S_RUN;
      ptr            <= 1'b0;
      outst          <= '0;
      tag_v          <= '0;
      tag_id         <= '0;
      bus.MADD_A     <= '0;
      bus.MADD_B     <= '0;
      bus.MADD_C     <= '0;
      bus.RSP0_VALID <= 1'b0;
      bus.RSP1_VALID <= 1'b0;
      bus.RSP0_Z     <= '0;
      bus.RSP1_Z     <= '0;
      bus.FLUSH_DONE <= 1'b0;
      bus.BUSY       <= 1'b0;
    end else begin
      outst    <= outst_next;
      bus.BUSY <= (outst_next != '0);
      if (accept) begin
        ptr        <= gnt0;
        bus.MADD_A <= acc_a;
        bus.MADD_B <= acc_b;
        bus.MADD_C <= acc_c;
      end
      tag_v[0]  <= accept;
      tag_id[0] <= gnt1;
      for (int i = 1; i < LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      bus.RSP0_VALID <= rsp_fire && !rsp_id;
      bus.RSP1_VALID <= rsp_fire && rsp_id;
      if (rsp_fire && !rsp_id) bus.RSP0_Z <= bus.MADD_Z;
      if (rsp_fire && rsp_id)  bus.RSP1_Z <= bus.MADD_Z;
      // FLUSH_DONE marks the one DRAIN cycle that sees an empty pipeline.
      case (state)
        S_RUN: begin
          bus.FLUSH_DONE <= 1'b0;
          if (bus.FLUSH) begin
            state          <= S_DRAIN;
            bus.FLUSH_DONE <= (outst_next == '0);
          end
        end
        S_DRAIN: begin
          if (outst == '0) begin
            state          <= S_RUN;
            bus.FLUSH_DONE <= 1'b0;
          end else begin
            bus.FLUSH_DONE <= (outst_next == '0);
          end
        end
        default: begin
          state          <= S_RUN;
          bus.FLUSH_DONE <= 1'b0;
        end
      endcase
    end
  end

`ifdef MADD_SCHED_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      ISSUE_CNT0 <= '0;
      ISSUE_CNT1 <= '0;
    end else begin
      if (gnt0) ISSUE_CNT0 <= ISSUE_CNT0 + 1'b1;
      if (gnt1) ISSUE_CNT1 <= ISSUE_CNT1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_madd_sched.sv
// Bench for madd_sched: directed scenarios plus random traffic checked against a
// response-schedule model (due cycle = accept cycle + LAT + 1).
module tb_madd_sched;
  localparam int LAT = 1;
  localparam int MO  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  madd_sched_if bus();
  madd_sched_if bus_m();
  logic st_main;
  logic st_m;

  // MADD unit: the operand register is its only stage when LAT = 1.
  assign bus.MADD_Z   = bus.MADD_A * bus.MADD_B + bus.MADD_C;
  assign bus_m.MADD_Z = bus_m.MADD_A * bus_m.MADD_B + bus_m.MADD_C;

`ifdef MADD_SCHED_STATS_EN
  logic [1:0]  ic0;
  logic [1:0]  ic1;
  logic [15:0] icm0;
  logic [15:0] icm1;
`endif

  madd_sched #(.LAT(LAT), .MAX_OUTST(MO), .CNT_W(2)) dut (
    .CLK(clk), .RST(rst), .bus(bus),
`ifdef MADD_SCHED_STATS_EN
    .ISSUE_CNT0(ic0), .ISSUE_CNT1(ic1),
`endif
    .fsm_state(st_main)
  );

  madd_sched #(.LAT(1), .MAX_OUTST(1)) dut_m (
    .CLK(clk), .RST(rst), .bus(bus_m),
`ifdef MADD_SCHED_STATS_EN
    .ISSUE_CNT0(icm0), .ISSUE_CNT1(icm1),
`endif
    .fsm_state(st_m)
  );

  typedef struct {
    int          due;
    logic        id;
    logic [31:0] z;
  } pend_t;

  pend_t       pq[$];
  int          cyc;
  int          n_tests;
  int          n_fail;
  logic        m_drain;
  logic        m_ptr;
  logic [31:0] m_a, m_b, m_c, m_z0, m_z1;
  int          m_acc0, m_acc1;
  logic        r0_seen, r1_seen, p0_seen, p1_seen, fd_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=0x%08h expected=0x%08h", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle_all();
    bus.REQ0_VALID = 1'b0; bus.REQ0_A = '0; bus.REQ0_B = '0; bus.REQ0_C = '0;
    bus.REQ1_VALID = 1'b0; bus.REQ1_A = '0; bus.REQ1_B = '0; bus.REQ1_C = '0;
    bus.FLUSH = 1'b0;
    bus_m.REQ0_VALID = 1'b0; bus_m.REQ0_A = '0; bus_m.REQ0_B = '0; bus_m.REQ0_C = '0;
    bus_m.REQ1_VALID = 1'b0; bus_m.REQ1_A = '0; bus_m.REQ1_B = '0; bus_m.REQ1_C = '0;
    bus_m.FLUSH = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    pq.delete();
    m_drain = 1'b0; m_ptr = 1'b0;
    m_a = '0; m_b = '0; m_c = '0; m_z0 = '0; m_z1 = '0;
    m_acc0 = 0; m_acc1 = 0;
  endtask

  function automatic logic [31:0] madd_ref(input logic [31:0] a, b, c);
    logic [63:0] full;
    full = {32'b0, a} * {32'b0, b} + {32'b0, c};
    return full[31:0];
  endfunction

  // One clock cycle: drive inputs, check every output against the model, advance.
  task automatic step(input logic v0, input logic [31:0] a0, b0, c0,
                      input logic v1, input logic [31:0] a1, b1, c1,
                      input logic fl);
    int    o;
    logic  g0, g1, e0, e1;
    pend_t p;
    bus.REQ0_VALID = v0; bus.REQ0_A = a0; bus.REQ0_B = b0; bus.REQ0_C = c0;
    bus.REQ1_VALID = v1; bus.REQ1_A = a1; bus.REQ1_B = b1; bus.REQ1_C = c1;
    bus.FLUSH = fl;
    #1;
    o = 0;
    e0 = 1'b0;
    e1 = 1'b0;
    foreach (pq[i]) begin
      if (pq[i].due > cyc) o++;
      if (pq[i].due == cyc) begin
        if (pq[i].id) begin e1 = 1'b1; m_z1 = pq[i].z; end
        else          begin e0 = 1'b1; m_z0 = pq[i].z; end
      end
    end
    g0 = !m_drain && !fl && (o < MO) && v0 && (!v1 || !m_ptr);
    g1 = !m_drain && !fl && (o < MO) && v1 && (!v0 || m_ptr);
    r0_seen = bus.REQ0_READY; r1_seen = bus.REQ1_READY;
    p0_seen = bus.RSP0_VALID; p1_seen = bus.RSP1_VALID;
    fd_seen = bus.FLUSH_DONE;
    chk("ready0", 32'(bus.REQ0_READY), 32'(g0));
    chk("ready1", 32'(bus.REQ1_READY), 32'(g1));
    chk("rsp0_valid", 32'(bus.RSP0_VALID), 32'(e0));
    chk("rsp1_valid", 32'(bus.RSP1_VALID), 32'(e1));
    chk("rsp0_z", bus.RSP0_Z, m_z0);
    chk("rsp1_z", bus.RSP1_Z, m_z1);
    chk("madd_a", bus.MADD_A, m_a);
    chk("madd_b", bus.MADD_B, m_b);
    chk("madd_c", bus.MADD_C, m_c);
    chk("flush_done", 32'(bus.FLUSH_DONE), 32'(m_drain && o == 0));
    chk("busy", 32'(bus.BUSY), 32'(o != 0));
    chk("fsm_state", 32'(st_main), 32'(m_drain));
`ifdef MADD_SCHED_STATS_EN
    chk("issue_cnt0", 32'(ic0), 32'(m_acc0 % 4));
    chk("issue_cnt1", 32'(ic1), 32'(m_acc1 % 4));
`endif
    if (g0 || g1) begin
      p.due = cyc + LAT + 1;
      p.id  = g1;
      m_a = g1 ? a1 : a0; m_b = g1 ? b1 : b0; m_c = g1 ? c1 : c0;
      p.z = madd_ref(m_a, m_b, m_c);
      pq.push_back(p);
      m_ptr = !g1;
      if (g1) m_acc1++; else m_acc0++;
    end
    if (!m_drain && fl)          m_drain = 1'b1;
    else if (m_drain && o == 0)  m_drain = 1'b0;
    while (pq.size() > 0 && pq[0].due <= cyc) void'(pq.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_step();
    step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  function automatic logic [31:0] rnd_op();
    return ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
  endfunction

  initial begin
    int f_cyc, done_cyc, resume_cyc, pulses, acc_m, last_acc;
    logic [31:0] pend_zm, am, bm, cm;
    logic exp_rdy;
    n_tests = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    idle_all();
    do_reset();

    // Reset state
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_madd_a", bus.MADD_A, 32'd0);
    chk("rst_rsp0_z", bus.RSP0_Z, 32'd0);
    chk("rst_rsp1_valid", 32'(bus.RSP1_VALID), 32'd0);
    chk("rst_flush_done", 32'(bus.FLUSH_DONE), 32'd0);

    // Single REQ0 op 3*5+7
    step(1'b1, 32'd3, 32'd5, 32'd7, 1'b0, '0, '0, '0, 1'b0);
    chk("tp1_ready0", 32'(r0_seen), 32'd1);
    idle_step();
    chk("tp1_rsp0_valid", 32'(bus.RSP0_VALID), 32'd1);
    chk("tp1_rsp0_z", bus.RSP0_Z, 32'h16);
    chk("tp1_rsp1_valid", 32'(bus.RSP1_VALID), 32'd0);
    idle_step();
    idle_step();

    // Both valid from pointer 0: grants alternate 0,1,0,1
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, $urandom, $urandom, $urandom, 1'b1, $urandom, $urandom, $urandom, 1'b0);
      chk($sformatf("tp2_grant%0d", k), {30'b0, r1_seen, r0_seen}, (k % 2 == 1) ? 32'd2 : 32'd1);
    end
    for (int k = 0; k < 3; k++) idle_step();

    // Random traffic with occasional flushes
    for (int k = 0; k < 200; k++) begin
      step($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), rnd_op(),
           $urandom_range(0, 3) != 0, rnd_op(), rnd_op(), rnd_op(),
           $urandom_range(0, 24) == 0);
    end
    for (int k = 0; k < 4; k++) idle_step();

    // Flush with two ops in flight
    do_reset();
    step(1'b1, $urandom, $urandom, $urandom, 1'b1, $urandom, $urandom, $urandom, 1'b0);
    step(1'b1, $urandom, $urandom, $urandom, 1'b1, $urandom, $urandom, $urandom, 1'b0);
    f_cyc = cyc;
    step(1'b1, $urandom, $urandom, $urandom, 1'b1, $urandom, $urandom, $urandom, 1'b1);
    chk("tp4_ready_on_flush", {30'b0, r1_seen, r0_seen}, 32'd0);
    pulses = int'(p0_seen) + int'(p1_seen);
    done_cyc = -1;
    resume_cyc = -1;
    for (int k = 0; k < 8 && resume_cyc < 0; k++) begin
      step(1'b1, $urandom, $urandom, $urandom, 1'b1, $urandom, $urandom, $urandom, 1'b0);
      if (fd_seen && done_cyc < 0) done_cyc = cyc - 1;
      if ((r0_seen || r1_seen) && resume_cyc < 0) resume_cyc = cyc - 1;
      else pulses += int'(p0_seen) + int'(p1_seen);
    end
    chk("tp4_rsp_pulses", 32'(pulses), 32'd2);
    chk("tp4_flush_done_cyc", 32'(done_cyc), 32'(f_cyc + 1));
    chk("tp4_resume_cyc", 32'(resume_cyc), 32'(f_cyc + 2));
    for (int k = 0; k < 3; k++) idle_step();

    // Reset with ops in flight
    step(1'b1, $urandom, $urandom, $urandom, 1'b1, $urandom, $urandom, $urandom, 1'b0);
    step(1'b1, $urandom, $urandom, $urandom, 1'b1, $urandom, $urandom, $urandom, 1'b0);
    do_reset();
    chk("tp5_busy", 32'(bus.BUSY), 32'd0);
    chk("tp5_madd_a", bus.MADD_A, 32'd0);
    chk("tp5_madd_b", bus.MADD_B, 32'd0);
    chk("tp5_madd_c", bus.MADD_C, 32'd0);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      idle_step();
      pulses += int'(p0_seen) + int'(p1_seen);
    end
    chk("tp5_no_rsp", 32'(pulses), 32'd0);

    // MAX_OUTST=1 instance, REQ0 held valid: accept every 2nd cycle
    do_reset();
    acc_m = 0;
    last_acc = -100;
    pend_zm = '0;
    for (int k = 0; k < 10; k++) begin
      am = rnd_op(); bm = rnd_op(); cm = rnd_op();
      bus_m.REQ0_VALID = 1'b1;
      bus_m.REQ0_A = am; bus_m.REQ0_B = bm; bus_m.REQ0_C = cm;
      #1;
      exp_rdy = (cyc - last_acc >= 2);
      chk("tp6_ready", 32'(bus_m.REQ0_READY), 32'(exp_rdy));
      chk("tp6_rsp_valid", 32'(bus_m.RSP0_VALID), 32'(cyc == last_acc + 2));
      if (cyc == last_acc + 2) chk("tp6_rsp_z", bus_m.RSP0_Z, pend_zm);
      chk("tp6_busy", 32'(bus_m.BUSY), 32'(cyc == last_acc + 1));
      if (bus_m.REQ0_READY) acc_m++;
      if (exp_rdy) begin
        last_acc = cyc;
        pend_zm = madd_ref(am, bm, cm);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("tp6_accepts", 32'(acc_m), 32'd5);
    bus_m.REQ0_VALID = 1'b0;

    // Five REQ1-only accepts
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, '0, '0, 1'b1, $urandom, $urandom, $urandom, 1'b0);
    end
`ifdef MADD_SCHED_STATS_EN
    chk("tp7_issue_cnt1", 32'(ic1), 32'd1);
    chk("tp7_issue_cnt0", 32'(ic0), 32'd0);
`endif
    for (int k = 0; k < 3; k++) idle_step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/madd_sched.md
Name: madd_sched

Overview:
- Round-robin scheduler that shares one pipelined MADD unit (Z = A*B + C, 32-bit) between two requesters.
- Accepts operand triples through valid/ready handshakes and registers them onto the MADD inputs.
- Tracks each in-flight operation's owner through a tag pipeline and returns each result to the requester that issued it.
- Provides a flush/drain sequence so the datapath can be quiesced before reconfiguration or test.

Parameters:
- LAT, 1, cycles from MADD_A/B/C presented to MADD_Z valid (≥1).
- MAX_OUTST, 2, maximum accepted-but-unreturned operations (1..LAT+1).
- CNT_W, 16, width of per-requester issue counters (optional feature only).

Ports:
- CLK  in  1  clock, all state updates on posedge.
- RST  in  1  synchronous reset, active-high.
- REQ0_VALID  in  1  requester 0 has an operand triple.
- REQ0_READY  out  1  requester 0 triple accepted this cycle if VALID.
- REQ0_A, REQ0_B, REQ0_C  in  32 each  requester 0 operands.
- REQ1_VALID, REQ1_READY, REQ1_A, REQ1_B, REQ1_C  same as requester 0, for requester 1.
- RSP0_VALID  out  1  one-cycle pulse: RSP0_Z holds a requester 0 result.
- RSP0_Z  out  32  requester 0 result.
- RSP1_VALID, RSP1_Z  same as requester 0, for requester 1.
- MADD_A, MADD_B, MADD_C  out  32 each  registered operands to the MADD.
- MADD_Z  in  32  MADD result.
- FLUSH  in  1  pulse: stop accepting requests and drain.
- FLUSH_DONE  out  1  one-cycle pulse: pipeline empty after a flush.
- BUSY  out  1  high while outstanding count is nonzero.

Behaviour:
- Reset values:
  - All READY, RSP*_VALID, FLUSH_DONE and BUSY are 0.
  - RSP*_Z and MADD_A/B/C are 0.
  - Priority pointer is 0, outstanding count is 0, tag pipeline is empty, FSM state is RUN.
- FSM RUN:
  - A request is grantable when state is RUN and outstanding < MAX_OUTST.
  - Grant goes to the single valid requester. If both are valid, grant goes to the requester named by the priority pointer.
  - READY is high only for the granted requester. READY is combinational from VALID, pointer, state and count.
  - Accept occurs when VALID and READY are both high.
  - On accept, the priority pointer moves to the other requester. With no accept, the pointer holds.
- Issue path:
  - The accepted triple is registered onto MADD_A/B/C at the next edge.
  - MADD_A/B/C hold their last values when no accept occurs.
  - A tag {valid, id} enters a shift register of depth LAT+1.
- Response path:
  - When the tag emerges, RSPid_VALID pulses and RSPid_Z is registered from MADD_Z.
  - Accept-to-RSP_VALID latency is LAT+1 cycles. With MAX_OUTST = LAT+1, sustained throughput is one op per cycle.
  - There is no response backpressure: a requester must take the result on the pulse cycle.
  - RSP*_Z holds its value between pulses.
- Outstanding count:
  - +1 on accept, −1 on response, unchanged when both happen in the same cycle.
  - The count never exceeds MAX_OUTST and never goes below 0.
- Arithmetic: the result is the low 32 bits of A*B + C, exactly as the MADD produces it. The scheduler does not modify data.
- FSM transitions:
  - RUN → DRAIN on FLUSH. FLUSH takes priority over an accept in the same cycle, so no grant is made that cycle.
  - DRAIN: READY is held at 0 and in-flight ops complete normally.
  - DRAIN → RUN when outstanding == 0, with FLUSH_DONE pulsed for exactly that cycle. The earliest pulse is one cycle after FLUSH.
  - FLUSH asserted while already in DRAIN is ignored.
- Reset mid-operation: in-flight tags are discarded and no RSP pulses occur for those ops. Reset overrides every other event.
- BUSY is registered from outstanding != 0.

Optional Feature:
- Macro: MADD_SCHED_STATS_EN.
- Defined:
  - Adds output ports ISSUE_CNT0 and ISSUE_CNT1 [CNT_W-1:0].
  - Each counter increments on accept by its requester, wraps modulo 2^CNT_W, and is cleared by RST.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then REQ0 only, A=3, B=5, C=7 (LAT=1) → REQ0_READY=1 on the accept cycle; RSP0_VALID pulses 2 cycles later with RSP0_Z=0x16; RSP1_VALID stays 0.
- Both VALID held for 4 cycles with pointer=0 → grants alternate 0,1,0,1; each response is routed to the correct RSP port in issue order.
- MAX_OUTST=1, LAT=1 with REQ0 held valid → accepts are every 2nd cycle; the count never exceeds 1.
- FLUSH with 2 ops in flight → READY=0 immediately; both RSP pulses still occur; FLUSH_DONE pulses on the cycle after the count reaches 0; accepts resume the following cycle.
- RST asserted for 1 cycle with 2 ops in flight → no RSP pulses follow; BUSY=0 and MADD_A/B/C=0 after reset.
- MADD_SCHED_STATS_EN defined, CNT_W=2, 5 accepts by REQ1 → ISSUE_CNT1=1 (wrap), ISSUE_CNT0=0.
